// File: rtl/ppu_regs_pkg.sv
// Shared definitions for the LCD register window: register offsets within
// the window, reset values and the PPU mode encoding.
package ppu_regs_pkg;

    // Register offsets relative to the start of the window
    localparam logic [3:0] ADDR_LCDC = 4'h0;
    localparam logic [3:0] ADDR_STAT = 4'h1;
    localparam logic [3:0] ADDR_SCY  = 4'h2;
    localparam logic [3:0] ADDR_SCX  = 4'h3;
    localparam logic [3:0] ADDR_LY   = 4'h4;
    localparam logic [3:0] ADDR_LYC  = 4'h5;
    localparam logic [3:0] ADDR_DMA  = 4'h6;
    localparam logic [3:0] ADDR_BGP  = 4'h7;
    localparam logic [3:0] ADDR_OBP0 = 4'h8;
    localparam logic [3:0] ADDR_OBP1 = 4'h9;
    localparam logic [3:0] ADDR_WY   = 4'hA;
    localparam logic [3:0] ADDR_WX   = 4'hB;

    localparam logic [15:0] WIN_LEN = 16'd12;

    // Power-on register contents
    localparam logic [7:0] LCDC_RST = 8'h91;
    localparam logic [7:0] BGP_RST  = 8'hFC;
    localparam logic [7:0] OBP_RST  = 8'hFF;
    localparam logic [7:0] DMA_RST  = 8'hFF;

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } ppu_mode_t;

endpackage

// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {page,00}.. into OAM 0..DMA_LEN-1.
// Source reads have one cycle of latency, so each OAM write trails its source
// address by one cycle. A new start restarts the copy from offset 0.
module ppu_oam_dma
    import ppu_regs_pkg::*;
#(
    parameter int DMA_LEN = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  start_page,
    input  logic [7:0]  dma_din,
    output logic [15:0] dma_src_a,
    output logic [7:0]  oam_dma_a,
    output logic [7:0]  oam_dma_din,
    output logic        oam_dma_wr,
    output logic        dma_active
);

    localparam logic [7:0] LEN8 = 8'(DMA_LEN);

    typedef enum logic {IDLE, RUN} dma_state_t;

    dma_state_t state;
    logic [7:0] k;
    logic [7:0] page;
    logic       wr_p1;
    logic [7:0] oam_a_p1;

    // Source counter and IDLE/RUN sequencing; the OAM write is the delayed copy of the source step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= 8'd0;
            page     <= 8'd0;
            wr_p1    <= 1'b0;
            oam_a_p1 <= 8'd0;
        end else if (start) begin
            // Restart drops any write still pending from the abandoned copy
            state <= RUN;
            k     <= 8'd0;
            page  <= start_page;
            wr_p1 <= 1'b0;
        end else if (state == RUN) begin
            wr_p1    <= (k != LEN8);
            oam_a_p1 <= k;
            if (k == LEN8) begin
                state <= IDLE;
            end else begin
                k <= k + 8'd1;
            end
        end else begin
            wr_p1 <= 1'b0;
        end
    end

    assign dma_active  = (state == RUN);
    assign dma_src_a   = (state == RUN && k != LEN8) ? ({page, 8'h00} + {8'h00, k}) : 16'h0000;
    assign oam_dma_wr  = wr_p1;
    assign oam_dma_a   = wr_p1 ? oam_a_p1 : 8'h00;
    assign oam_dma_din = wr_p1 ? dma_din : 8'h00;

endmodule

// File: rtl/ppu_lcd_regs.sv
// LCD register block (FF40-FF4B by default): holds the PPU control registers,
// answers MMIO reads, and raises VBLANK / STAT interrupt pulses.
// Optional OAM DMA engine on FF46 is built when PPU_OAM_DMA_EN is defined;
// otherwise FF46 is a plain read/write register and the DMA outputs are 0.
module ppu_lcd_regs
    import ppu_regs_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF40,
    parameter int          DMA_LEN   = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mmio_a,
    input  logic [7:0]  mmio_din,
    input  logic        mmio_wr,
    input  logic        mmio_rd,
    output logic [7:0]  mmio_dout,
    output logic        mmio_hit,
    input  logic [1:0]  ppu_mode,
    input  logic [7:0]  ppu_ly,
    output logic [7:0]  lcdc,
    output logic [7:0]  scy,
    output logic [7:0]  scx,
    output logic [7:0]  bgp,
    output logic [7:0]  obp0,
    output logic [7:0]  obp1,
    output logic [7:0]  wy,
    output logic [7:0]  wx,
    output logic        ly_reset,
    output logic        irq_vblank,
    output logic        irq_stat,
    output logic [15:0] dma_src_a,
    input  logic [7:0]  dma_din,
    output logic [7:0]  oam_dma_a,
    output logic [7:0]  oam_dma_din,
    output logic        oam_dma_wr,
    output logic        dma_active
);

    logic [15:0] off;
    logic        in_win;
    logic [3:0]  sel;
    logic        wr_hit;
    logic [3:0]  stat_en;      // STAT bits 6:3
    logic [7:0]  lyc;
    logic [7:0]  dma_reg;
    logic        lcd_on;
    ppu_mode_t   mode_eff;
    ppu_mode_t   mode_p1;
    logic        coin_d;
    logic        coin_p1;
    logic        stat_line_d;
    logic        stat_line_p1;
    logic [7:0]  rdata;

    assign off    = mmio_a - BASE_ADDR;
    assign in_win = (mmio_a >= BASE_ADDR) && (off < WIN_LEN);
    assign sel    = off[3:0];
    assign wr_hit = mmio_wr && in_win;
    assign lcd_on = lcdc[7];

    // With the LCD off the core's mode, line compare and interrupts are all masked
    assign mode_eff    = lcd_on ? ppu_mode_t'(ppu_mode) : HBLANK;
    assign coin_d      = lcd_on && (ppu_ly == lyc);
    assign stat_line_d = lcd_on && ((stat_en[3] && coin_d) ||
                                    (stat_en[2] && mode_eff == OAM) ||
                                    (stat_en[1] && mode_eff == VBLANK) ||
                                    (stat_en[0] && mode_eff == HBLANK));

    // Register writes; FF44 has no storage and only pulses ly_reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcdc     <= LCDC_RST;
            stat_en  <= 4'h0;
            scy      <= 8'h00;
            scx      <= 8'h00;
            lyc      <= 8'h00;
            dma_reg  <= DMA_RST;
            bgp      <= BGP_RST;
            obp0     <= OBP_RST;
            obp1     <= OBP_RST;
            wy       <= 8'h00;
            wx       <= 8'h00;
            ly_reset <= 1'b0;
        end else begin
            ly_reset <= wr_hit && (sel == ADDR_LY);
            if (wr_hit) begin
                case (sel)
                    ADDR_LCDC: lcdc    <= mmio_din;
                    ADDR_STAT: stat_en <= mmio_din[6:3];
                    ADDR_SCY:  scy     <= mmio_din;
                    ADDR_SCX:  scx     <= mmio_din;
                    ADDR_LYC:  lyc     <= mmio_din;
                    ADDR_DMA:  dma_reg <= mmio_din;
                    ADDR_BGP:  bgp     <= mmio_din;
                    ADDR_OBP0: obp0    <= mmio_din;
                    ADDR_OBP1: obp1    <= mmio_din;
                    ADDR_WY:   wy      <= mmio_din;
                    ADDR_WX:   wx      <= mmio_din;
                    default:   ;
                endcase
            end
        end
    end

    // Coincidence flag, mode history and edge-detected interrupt pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_p1      <= 1'b0;
            mode_p1      <= HBLANK;
            stat_line_p1 <= 1'b0;
            irq_vblank   <= 1'b0;
            irq_stat     <= 1'b0;
        end else begin
            coin_p1      <= coin_d;
            mode_p1      <= mode_eff;
            stat_line_p1 <= stat_line_d;
            irq_vblank   <= lcd_on && (mode_eff == VBLANK) && (mode_p1 != VBLANK);
            irq_stat     <= stat_line_d && !stat_line_p1;
        end
    end

    // Read mux; sees pre-edge register contents so a same-cycle write reads old data
    always_comb begin
        rdata = 8'hFF;
        case (sel)
            ADDR_LCDC: rdata = lcdc;
            ADDR_STAT: rdata = {1'b1, stat_en, coin_p1, mode_eff};
            ADDR_SCY:  rdata = scy;
            ADDR_SCX:  rdata = scx;
            ADDR_LY:   rdata = lcd_on ? ppu_ly : 8'h00;
            ADDR_LYC:  rdata = lyc;
            ADDR_DMA:  rdata = dma_reg;
            ADDR_BGP:  rdata = bgp;
            ADDR_OBP0: rdata = obp0;
            ADDR_OBP1: rdata = obp1;
            ADDR_WY:   rdata = wy;
            ADDR_WX:   rdata = wx;
            default:   rdata = 8'hFF;
        endcase
    end

    // Registered read response; out-of-window reads return FF with no hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_dout <= 8'h00;
            mmio_hit  <= 1'b0;
        end else if (mmio_rd) begin
            mmio_hit  <= in_win;
            mmio_dout <= in_win ? rdata : 8'hFF;
        end else begin
            mmio_hit  <= 1'b0;
        end
    end

`ifdef PPU_OAM_DMA_EN
    ppu_oam_dma #(
        .DMA_LEN (DMA_LEN)
    ) u_oam_dma (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (wr_hit && (sel == ADDR_DMA)),
        .start_page  (mmio_din),
        .dma_din     (dma_din),
        .dma_src_a   (dma_src_a),
        .oam_dma_a   (oam_dma_a),
        .oam_dma_din (oam_dma_din),
        .oam_dma_wr  (oam_dma_wr),
        .dma_active  (dma_active)
    );
`else
    logic unused_dma;
    assign unused_dma  = ^{dma_din, 8'(DMA_LEN)};
    assign dma_src_a   = 16'h0000;
    assign oam_dma_a   = 8'h00;
    assign oam_dma_din = 8'h00;
    assign oam_dma_wr  = 1'b0;
    assign dma_active  = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_lcd_regs.sv
// Directed testbench for ppu_lcd_regs. Define PPU_OAM_DMA_EN for both the
// bench and the RTL to exercise the OAM DMA engine.
module tb_ppu_lcd_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mmio_a;
    logic [7:0]  mmio_din;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [7:0]  mmio_dout;
    logic        mmio_hit;
    logic [1:0]  ppu_mode;
    logic [7:0]  ppu_ly;
    logic [7:0]  lcdc, scy, scx, bgp, obp0, obp1, wy, wx;
    logic        ly_reset, irq_vblank, irq_stat;
    logic [15:0] dma_src_a;
    logic [7:0]  dma_din = 8'h00;
    logic [7:0]  oam_dma_a, oam_dma_din;
    logic        oam_dma_wr, dma_active;

    int checks = 0;
    int errors = 0;

    ppu_lcd_regs dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mmio_a      (mmio_a),
        .mmio_din    (mmio_din),
        .mmio_wr     (mmio_wr),
        .mmio_rd     (mmio_rd),
        .mmio_dout   (mmio_dout),
        .mmio_hit    (mmio_hit),
        .ppu_mode    (ppu_mode),
        .ppu_ly      (ppu_ly),
        .lcdc        (lcdc),
        .scy         (scy),
        .scx         (scx),
        .bgp         (bgp),
        .obp0        (obp0),
        .obp1        (obp1),
        .wy          (wy),
        .wx          (wx),
        .ly_reset    (ly_reset),
        .irq_vblank  (irq_vblank),
        .irq_stat    (irq_stat),
        .dma_src_a   (dma_src_a),
        .dma_din     (dma_din),
        .oam_dma_a   (oam_dma_a),
        .oam_dma_din (oam_dma_din),
        .oam_dma_wr  (oam_dma_wr),
        .dma_active  (dma_active)
    );

    always #5 clk = ~clk;

    // Source memory model: byte at address A is A[7:0]+3, one cycle of latency
    always @(posedge clk) dma_din <= dma_src_a[7:0] + 8'h03;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        mmio_a   = a;
        mmio_din = d;
        mmio_wr  = 1'b1;
        tick();
        mmio_wr  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        mmio_a  = a;
        mmio_rd = 1'b1;
        tick();
        mmio_rd = 1'b0;
    endtask

`ifdef PPU_OAM_DMA_EN
    // Follows one full copy starting from the cycle after the FF46 write
    task automatic dma_run_check(input logic [7:0] page);
        int act;
        int nw;
        act = 0;
        nw  = 0;
        for (int c = 0; c < 170; c++) begin
            if (dma_active) act++;
            if (c < 160) chk("dma_src_a", dma_src_a, {page, 8'h00} + 16'(c));
            if (oam_dma_wr) begin
                chk("oam_dma_a", {8'h00, oam_dma_a}, 16'(nw));
                chk("oam_dma_din", {8'h00, oam_dma_din}, {8'h00, 8'(nw) + 8'h03});
                nw++;
            end
            tick();
        end
        chk("dma_active_cycles", 16'(act), 16'd161);
        chk("oam_write_count", 16'(nw), 16'd160);
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        mmio_a   = 16'h0000;
        mmio_din = 8'h00;
        mmio_wr  = 1'b0;
        mmio_rd  = 1'b0;
        ppu_mode = 2'd0;
        ppu_ly   = 8'd5;
        tick();
        tick();

        // Reset state
        chk("rst_lcdc", {8'h0, lcdc}, 16'h0091);
        chk("rst_bgp",  {8'h0, bgp},  16'h00FC);
        chk("rst_obp0", {8'h0, obp0}, 16'h00FF);
        chk("rst_obp1", {8'h0, obp1}, 16'h00FF);
        chk("rst_scy",  {8'h0, scy},  16'h0000);
        chk("rst_wx",   {8'h0, wx},   16'h0000);
        chk("rst_dout", {8'h0, mmio_dout}, 16'h0000);
        chk("rst_hit",  {15'h0, mmio_hit}, 16'h0);
        chk("rst_irqs", {13'h0, irq_stat, irq_vblank, ly_reset}, 16'h0);
        chk("rst_dma",  {15'h0, dma_active}, 16'h0);
        rst_n = 1'b1;
        tick();
        rd(16'hFF46);
        chk("dma_reg_rst", {7'h0, mmio_hit, mmio_dout}, 16'h01FF);

        // Plain write / readback
        wr(16'hFF42, 8'h37);
        chk("scy_out", {8'h0, scy}, 16'h0037);
        rd(16'hFF42);
        chk("scy_read", {7'h0, mmio_hit, mmio_dout}, 16'h0137);

        // STAT enable while mode 2 already holds -> one irq_stat pulse
        ppu_mode = 2'd2;
        tick();
        wr(16'hFF41, 8'hFF);
        chk("stat_irq_pre", {15'h0, irq_stat}, 16'h0);
        tick();
        chk("stat_irq_pulse", {15'h0, irq_stat}, 16'h1);
        tick();
        chk("stat_irq_once", {15'h0, irq_stat}, 16'h0);
        rd(16'hFF41);
        chk("stat_read", {7'h0, mmio_hit, mmio_dout}, 16'h01FA);

        // LY=LYC coincidence with only the coincidence source able to fire
        ppu_mode = 2'd3;
        wr(16'hFF45, 8'd10);
        ppu_ly = 8'd9;
        tick();
        chk("coin_ly9", {15'h0, irq_stat}, 16'h0);
        ppu_ly = 8'd10;
        tick();
        chk("coin_irq", {15'h0, irq_stat}, 16'h1);
        tick();
        chk("coin_irq_once", {15'h0, irq_stat}, 16'h0);
        rd(16'hFF41);
        chk("stat_coin_read", {8'h0, mmio_dout}, 16'h00FF);
        ppu_ly = 8'd11;
        tick();
        chk("coin_ly11_irq", {15'h0, irq_stat}, 16'h0);
        rd(16'hFF41);
        chk("stat_nocoin_read", {8'h0, mmio_dout}, 16'h00FB);

        // VBLANK entry pulse
        ppu_mode = 2'd0;
        tick();
        tick();
        ppu_mode = 2'd1;
        tick();
        chk("vblank_pulse", {15'h0, irq_vblank}, 16'h1);
        tick();
        chk("vblank_once", {15'h0, irq_vblank}, 16'h0);

        // LCD off masks mode, LY and interrupts
        wr(16'hFF40, 8'h11);
        chk("lcdc_off", {8'h0, lcdc}, 16'h0011);
        ppu_mode = 2'd0;
        tick();
        ppu_mode = 2'd1;
        tick();
        chk("vblank_off", {14'h0, irq_vblank, irq_stat}, 16'h0);
        tick();
        chk("vblank_off2", {14'h0, irq_vblank, irq_stat}, 16'h0);
        rd(16'hFF44);
        chk("ly_off_read", {7'h0, mmio_hit, mmio_dout}, 16'h0100);
        rd(16'hFF41);
        chk("stat_off_read", {8'h0, mmio_dout}, 16'h00F8);

        // Out-of-window reads
        rd(16'hFF3F);
        chk("read_ff3f", {7'h0, mmio_hit, mmio_dout}, 16'h00FF);
        rd(16'hFF4C);
        chk("read_ff4c", {7'h0, mmio_hit, mmio_dout}, 16'h00FF);

        // FF44 write pulses ly_reset; LY still reads ppu_ly
        wr(16'hFF40, 8'h91);
        wr(16'hFF44, 8'h55);
        chk("ly_reset_pulse", {15'h0, ly_reset}, 16'h1);
        tick();
        chk("ly_reset_once", {15'h0, ly_reset}, 16'h0);
        rd(16'hFF44);
        chk("ly_read", {7'h0, mmio_hit, mmio_dout}, 16'h010B);

        // Same-cycle write and read of one address returns the old value
        mmio_a   = 16'hFF47;
        mmio_din = 8'hAA;
        mmio_wr  = 1'b1;
        mmio_rd  = 1'b1;
        tick();
        mmio_wr  = 1'b0;
        mmio_rd  = 1'b0;
        chk("wr_rd_old", {7'h0, mmio_hit, mmio_dout}, 16'h01FC);
        chk("wr_rd_bgp", {8'h0, bgp}, 16'h00AA);

`ifdef PPU_OAM_DMA_EN
        // Full OAM DMA from page C0
        wr(16'hFF46, 8'hC0);
        dma_run_check(8'hC0);
        chk("dma_idle", {15'h0, dma_active}, 16'h0);
        rd(16'hFF46);
        chk("dma_reg_read", {8'h0, mmio_dout}, 16'h00C0);

        // Rewrite at k=50 restarts from C000
        wr(16'hFF46, 8'hC0);
        repeat (50) tick();
        chk("dma_k50", dma_src_a, 16'hC032);
        wr(16'hFF46, 8'hC0);
        dma_run_check(8'hC0);
`else
        // Plain FF46 register, DMA outputs stay idle
        wr(16'hFF46, 8'hC0);
        tick();
        chk("dma_off_outputs", {dma_src_a[7:0], oam_dma_a, oam_dma_din, 5'h0, oam_dma_wr, dma_active, 1'b0} == 32'h0 ? 16'h0 : 16'h1, 16'h0);
        rd(16'hFF46);
        chk("dma_reg_read", {8'h0, mmio_dout}, 16'h00C0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_lcd_regs.md
Name: ppu_lcd_regs

Overview:
- Responder for the CPU/debug MMIO write port (mmio_a/mmio_din/mmio_wr) covering the LCD register window FF40–FF4B.
- Holds LCDC, STAT, SCY, SCX, LYC, BGP, OBP0, OBP1, WY and WX, and returns LY and the STAT mode bits.
- Generates the VBLANK and STAT interrupt pulses from PPU status.
- Sits between the MMIO bus and the PPU core; all register values go to the core as flat outputs.

Parameters:
- BASE_ADDR, 16'hFF40, first address of the register window (window is 12 bytes).
- DMA_LEN, 160, bytes copied per OAM DMA (used only with the optional feature).

Ports:
- clk  in  1  system clock (4 MHz domain)
- rst_n  in  1  asynchronous reset, active-low
- mmio_a  in  16  bus address
- mmio_din  in  8  write data
- mmio_wr  in  1  write strobe, one cycle per write
- mmio_rd  in  1  read strobe
- mmio_dout  out  8  read data, registered
- mmio_hit  out  1  registered; high the cycle mmio_dout is valid for an in-window read
- ppu_mode  in  2  current PPU mode: 0 HBLANK, 1 VBLANK, 2 OAM, 3 XFER
- ppu_ly  in  8  current PPU line
- lcdc, scy, scx, bgp, obp0, obp1, wy, wx  out  8 each  register values to the core
- ly_reset  out  1  one-cycle pulse on any write to FF44
- irq_vblank  out  1  one-cycle pulse
- irq_stat  out  1  one-cycle pulse
- dma_src_a  out  16  source read address (DMA)
- dma_din  in  8  source read data, 1-cycle latency (DMA)
- oam_dma_a  out  8  OAM write address (DMA)
- oam_dma_din  out  8  OAM write data (DMA)
- oam_dma_wr  out  1  OAM write strobe (DMA)
- dma_active  out  1  DMA in progress

Behaviour:
- Reset values (async on rst_n low):
  - lcdc = 8'h91; STAT enables = 0; scy, scx, lyc, wy, wx = 0.
  - bgp = 8'hFC; obp0, obp1 = 8'hFF; DMA register = 8'hFF.
  - All pulse outputs, mmio_hit and mmio_dout = 0.
- Writes:
  - Take effect on the clk edge where mmio_wr=1 and the address is in the window; the new value is visible on outputs the next cycle.
  - STAT writes update bits 6:3 only.
  - Writes to FF44 leave storage unchanged and pulse ly_reset.
- Reads:
  - mmio_rd with an in-window address returns data the next cycle with mmio_hit=1.
  - Out-of-window address: mmio_hit=0 and mmio_dout=8'hFF.
  - STAT readback = {1, en[6:3], coincidence, mode}.
  - LY readback = ppu_ly.
- LCD off (lcdc[7]=0): STAT mode reads 0, LY reads 0, coincidence is forced 0, no interrupts are generated.
- Coincidence: registered (ppu_ly == lyc); 1-cycle lag behind a ppu_ly change or an LYC write. If a write and a ppu_ly change land in the same cycle, the comparison uses the post-edge values.
- irq_vblank: pulses the cycle after ppu_mode enters 1 from any other mode.
- STAT line = OR of (en6 & coincidence), (en5 & mode==2), (en4 & mode==1), (en3 & mode==0).
  - irq_stat pulses on the line's rising edge only; the line staying high never re-triggers.
  - Enabling a source while its condition already holds counts as a rising edge.
- Simultaneous mmio_wr and mmio_rd to the same address: the read returns the old value.

Optional Feature:
- Macro: PPU_OAM_DMA_EN.
- With the macro defined, a write of V to FF46 starts the DMA engine:
  - Cycle k (k=0..DMA_LEN-1) drives dma_src_a = {V, 8'h00} + k.
  - Cycle k+1 asserts oam_dma_wr with oam_dma_a = k and oam_dma_din = dma_din.
  - dma_active is high from the cycle after the write through the last OAM write (DMA_LEN+1 cycles).
  - A new FF46 write during an active DMA restarts the copy from k=0 with the new source.
  - Reset mid-DMA aborts immediately.
  - FF46 reads return V.
- Without the macro, FF46 is a plain R/W register, and all DMA outputs are tied to 0.

Decomposition:
- Package ppu_regs_pkg holds:
  - address localparams ADDR_LCDC…ADDR_WX and ADDR_DMA;
  - reset-value constants;
  - a typedef enum logic[1:0] ppu_mode_t {HBLANK, VBLANK, OAM, XFER}.
- One sub-module, ppu_oam_dma: counter plus IDLE/RUN FSM, instantiated only under PPU_OAM_DMA_EN.

Test Plan:
- Write FF42=8'h37, then read FF42 → scy=8'h37 the next cycle; mmio_dout=8'h37 with mmio_hit=1 one cycle after mmio_rd.
- Write STAT=8'hFF with ppu_mode=2, lcdc=8'h91 → STAT reads 8'hFA (bits 6:3 set, mode=2, no coincidence); irq_stat pulses once.
- lyc=8'd10, step ppu_ly 9→10→11 with en6=1 → coincidence 1 for exactly one line; a single irq_stat pulse one cycle after ppu_ly=10.
- ppu_mode 0→1 → irq_vblank single pulse; clear lcdc[7] and repeat → no pulse; LY reads 0.
- Read FF3F and FF4C → mmio_hit=0, mmio_dout=8'hFF; write FF44=8'h55 → ly_reset pulse, readback still ppu_ly.
- PPU_OAM_DMA_EN: write FF46=8'hC0, source = incrementing bytes → 160 OAM writes, addr 0..159, data = source, dma_active high for 161 cycles; a rewrite at k=50 restarts at dma_src_a=16'hC000.
